timer_sequencer: RTL
====================

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000000: clock cycles per one-second tick.
REQ-002 Parameter DEBOUNCE_CYC, default 1000000: consecutive stable synchronized cycles required to accept a button level.
REQ-003 Parameter ALARM_SECS, default 10: alarm duration in ticks before auto-return to IDLE.
REQ-004 clock  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_start, btn_pause, btn_min, btn_sec  input  1 each  raw asynchronous push-buttons, active-high.
REQ-007 count_done  input  1  level from the timer datapath; high means countdown reached 00:00.
REQ-008 cmd_start, cmd_pause, cmd_get_min, cmd_get_sec  output  1 each  single-cycle command pulses to the timer datapath.
REQ-009 tick  output  1  single-cycle pulse per elapsed second while running.
REQ-010 alarm_led  output  1  blinking alarm indicator.
REQ-011 mode  output  2  current state encoding: IDLE=0, RUN=1, HOLD=2, ALARM=3.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a per-button debounce counter; the debounced level updates only after DEBOUNCE_CYC consecutive cycles of the same synchronized value differing from it, and the counter clears on any mismatch.
REQ-013 A button event SHALL be a rising edge of its debounced level; the cmd pulse SHALL assert exactly DEBOUNCE_CYC+3 cycles after the first raw-high sample, assuming the raw input stays high; falling edges generate nothing.
REQ-014 At most one command SHALL issue per cycle; simultaneous events resolve by priority pause > start > min > sec; lower-priority events in the same cycle are discarded, not queued.
REQ-015 IDLE: start event -> cmd_start, go RUN, prescaler cleared to 0; min event -> cmd_get_min, stay IDLE; sec event -> cmd_get_sec, stay IDLE; pause event ignored.
REQ-016 RUN: pause event -> cmd_pause, go HOLD; start/min/sec events ignored; count_done high -> go ALARM with no cmd, prescaler stops.
REQ-017 count_done SHALL take precedence over a same-cycle pause event in RUN; no cmd_pause is emitted.
REQ-018 HOLD: pause event -> cmd_pause, go RUN; prescaler value SHALL be held, so the partial second is preserved; all other events ignored.
REQ-019 Prescaler: counts 0..TICK_DIV-1 only in RUN; tick pulses for one cycle when count wraps from TICK_DIV-1 to 0; no tick in IDLE, HOLD or ALARM.
REQ-020 ALARM: a separate second counter runs from entry; alarm_led goes 1 on entry and toggles each second; after ALARM_SECS seconds, or on any button event (whichever first), go IDLE with alarm_led 0 and no cmd emitted.
REQ-021 Outside ALARM, alarm_led SHALL be 0.
REQ-022 Counter widths SHALL be $clog2 of the respective parameter plus 1; no wrap other than the defined terminal counts.

Reset
REQ-023 With reset high at a clock edge: mode=IDLE, all cmd outputs=0, tick=0, alarm_led=0, prescaler, alarm counters, debounce counters, synchronizers and debounced levels=0.
REQ-024 Reset SHALL override every event in the same cycle; reset mid-RUN or mid-ALARM returns to IDLE with no pulse issued; a button held across reset release produces an event once debounced.

Verification (DEBOUNCE_CYC=4, TICK_DIV=10, ALARM_SECS=3)
REQ-025 Reset, btn_min held high from cycle 0 -> single cmd_get_min at cycle 7, mode stays 0; a 3-cycle glitch on btn_sec -> no cmd.
REQ-026 Start pressed in IDLE -> cmd_start, mode=1; tick every 10 cycles thereafter, first tick 10 cycles after cmd_start.
REQ-027 Pause 4 cycles after a tick -> cmd_pause, mode=2, no ticks for 50 cycles; second pause -> mode=1, next tick 6 cycles later.
REQ-028 btn_pause and btn_start rising together in IDLE -> no command (pause ignored, start discarded), mode=0; same in RUN -> only cmd_pause.
REQ-029 count_done high in RUN -> mode=3, alarm_led 1 for 10 cycles then 0 then 1, return to mode=0 after 30 cycles; repeat with button pressed in ALARM -> immediate IDLE, no cmd.
REQ-030 Reset asserted during RUN -> next cycle mode=0, tick=0, all cmds 0, prescaler 0.

Source files
------------

// File: rtl/timer_sequencer.sv
// Button-driven control sequencer for a countdown timer: debounces four buttons,
// arbitrates them into datapath commands, and drives the one-second tick and alarm blink.
module timer_sequencer #(
   parameter int TICK_DIV     = 100000000,
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int ALARM_SECS   = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       btn_min,
   input  logic       btn_sec,
   input  logic       count_done,
   output logic       cmd_start,
   output logic       cmd_pause,
   output logic       cmd_get_min,
   output logic       cmd_get_sec,
   output logic       tick,
   output logic       alarm_led,
   output logic [1:0] mode
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_ALARM = 2'd3;

   localparam int PW = $clog2(TICK_DIV) + 1;
   localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
   localparam int SW = $clog2(ALARM_SECS) + 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [SW-1:0] ASEC_LAST  = SW'(ALARM_SECS - 1);

   // Bit order doubles as priority: pause(3) > start(2) > min(1) > sec(0).
   logic [3:0] btn_raw;
   logic [3:0] deb_level;
   logic [3:0] deb_prev_reg;
   logic [3:0] event_reg;

   assign btn_raw = {btn_pause, btn_start, btn_min, btn_sec};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         logic          sync1_reg;
         logic          sync2_reg;
         logic          deb_reg;
         logic [DW-1:0] cnt_reg;

         always_ff @(posedge clock) begin
            if (reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DEB_LAST) begin
                  deb_reg <= sync2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + DW'(1);
               end
            end
         end

         assign deb_level[gi] = deb_reg;
      end
   endgenerate

   // Registering the edge keeps the command exactly DEBOUNCE_CYC+3 cycles behind the press.
   always_ff @(posedge clock) begin
      if (reset) begin
         deb_prev_reg <= '0;
         event_reg    <= '0;
      end else begin
         deb_prev_reg <= deb_level;
         event_reg    <= deb_level & ~deb_prev_reg;
      end
   end

   logic win_pause, win_start, win_min, win_sec, any_event;

   assign win_pause = event_reg[3];
   assign win_start = event_reg[2] & ~event_reg[3];
   assign win_min   = event_reg[1] & ~(|event_reg[3:2]);
   assign win_sec   = event_reg[0] & ~(|event_reg[3:1]);
   assign any_event = |event_reg;

   logic [1:0]    state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [PW-1:0] apre_reg, apre_next;
   logic [SW-1:0] asec_reg, asec_next;
   logic          led_reg, led_next;
   logic          tick_reg, tick_next;
   logic          cmd_start_reg, cmd_start_next;
   logic          cmd_pause_reg, cmd_pause_next;
   logic          cmd_min_reg, cmd_min_next;
   logic          cmd_sec_reg, cmd_sec_next;

   always_comb begin
      state_next     = state_reg;
      presc_next     = presc_reg;
      apre_next      = apre_reg;
      asec_next      = asec_reg;
      led_next       = 1'b0;
      tick_next      = 1'b0;
      cmd_start_next = 1'b0;
      cmd_pause_next = 1'b0;
      cmd_min_next   = 1'b0;
      cmd_sec_next   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (win_start) begin
               cmd_start_next = 1'b1;
               state_next     = ST_RUN;
               presc_next     = '0;
            end else if (win_min) begin
               cmd_min_next = 1'b1;
            end else if (win_sec) begin
               cmd_sec_next = 1'b1;
            end
         end
         ST_RUN: begin
            // Reaching 00:00 beats a simultaneous pause and freezes the prescaler.
            if (count_done) begin
               state_next = ST_ALARM;
               led_next   = 1'b1;
               apre_next  = '0;
               asec_next  = '0;
            end else begin
               if (presc_reg == PRESC_LAST) begin
                  presc_next = '0;
                  tick_next  = 1'b1;
               end else begin
                  presc_next = presc_reg + PW'(1);
               end
               if (win_pause) begin
                  cmd_pause_next = 1'b1;
                  state_next     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (win_pause) begin
               cmd_pause_next = 1'b1;
               state_next     = ST_RUN;
            end
         end
         default: begin
            led_next = led_reg;
            if (any_event) begin
               state_next = ST_IDLE;
               led_next   = 1'b0;
            end else if (apre_reg == PRESC_LAST) begin
               apre_next = '0;
               if (asec_reg == ASEC_LAST) begin
                  state_next = ST_IDLE;
                  led_next   = 1'b0;
               end else begin
                  asec_next = asec_reg + SW'(1);
                  led_next  = ~led_reg;
               end
            end else begin
               apre_next = apre_reg + PW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         presc_reg     <= '0;
         apre_reg      <= '0;
         asec_reg      <= '0;
         led_reg       <= 1'b0;
         tick_reg      <= 1'b0;
         cmd_start_reg <= 1'b0;
         cmd_pause_reg <= 1'b0;
         cmd_min_reg   <= 1'b0;
         cmd_sec_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         presc_reg     <= presc_next;
         apre_reg      <= apre_next;
         asec_reg      <= asec_next;
         led_reg       <= led_next;
         tick_reg      <= tick_next;
         cmd_start_reg <= cmd_start_next;
         cmd_pause_reg <= cmd_pause_next;
         cmd_min_reg   <= cmd_min_next;
         cmd_sec_reg   <= cmd_sec_next;
      end
   end

   assign mode        = state_reg;
   assign tick        = tick_reg;
   assign alarm_led   = led_reg;
   assign cmd_start   = cmd_start_reg;
   assign cmd_pause   = cmd_pause_reg;
   assign cmd_get_min = cmd_min_reg;
   assign cmd_get_sec = cmd_sec_reg;

endmodule
